// File: rtl/stream_arb_pkg.sv
// Shared types and the cyclic priority search used by the flushable round-robin arbiter.
package stream_arb_pkg;

  typedef enum logic [1:0] {
    FlIdle  = 2'd0,
    FlFlush = 2'd1,
    FlAck   = 2'd2
  } flush_state_e;

  localparam int unsigned MaxIn   = 32;
  localparam int unsigned MaxIdxW = 5;

  typedef struct packed {
    logic               found;
    logic [MaxIdxW-1:0] idx;
  } rr_pick_t;

  // First set bit of valid[num-1:0], scanning upward from ptr and wrapping at num.
  function automatic rr_pick_t rr_pick(input logic [MaxIn-1:0] valid,
                                       input int unsigned      ptr,
                                       input int unsigned      num);
    rr_pick_t    res;
    int unsigned k;
    res = '0;
    for (int unsigned i = 0; i < MaxIn; i++) begin
      if (i < num && !res.found) begin
        k = ptr + i;
        if (k >= num) k = k - num;
        if (valid[k]) begin
          res.found = 1'b1;
          res.idx   = MaxIdxW'(k);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/spill_register_flushable.sv
// Two-entry spill register with a synchronous flush; ready_o never depends on ready_i.
module spill_register_flushable #(
  parameter type  T      = logic,
  parameter logic Bypass = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  input  logic flush_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);

  if (Bypass) begin : gen_bypass
    assign valid_o = valid_i;
    assign ready_o = ready_i;
    assign data_o  = data_i;
  end else begin : gen_spill
    T     a_data_q, b_data_q;
    logic a_full_q, b_full_q;
    logic a_fill, a_drain, b_fill, b_drain;

    // Slot a takes new beats; it drains either downstream or into slot b when the consumer stalls.
    assign a_fill  = valid_i & ready_o;
    assign a_drain = a_full_q & ~b_full_q;
    assign b_fill  = a_drain & ~ready_i;
    assign b_drain = b_full_q & ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        a_full_q <= 1'b0;
        b_full_q <= 1'b0;
        a_data_q <= '0;
        b_data_q <= '0;
      end else begin
        if (flush_i) begin
          a_full_q <= 1'b0;
        end else if (a_fill || a_drain) begin
          a_full_q <= a_fill;
        end
        if (a_fill) a_data_q <= data_i;

        if (flush_i) begin
          b_full_q <= 1'b0;
        end else if (b_fill || b_drain) begin
          b_full_q <= b_fill;
        end
        if (b_fill) b_data_q <= a_data_q;
      end
    end

    assign ready_o = ~a_full_q | ~b_full_q;
    assign valid_o = a_full_q | b_full_q;
    assign data_o  = b_full_q ? b_data_q : a_data_q;
  end

endmodule

// File: rtl/stream_rr_arbiter_flushable.sv
// Round-robin arbiter feeding one registered, flushable output channel with a flush handshake.
module stream_rr_arbiter_flushable
  import stream_arb_pkg::*;
#(
  parameter int unsigned NumIn = 4,
  parameter type         T     = logic [31:0],
  parameter int unsigned IdxW  = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NumIn-1:0] inp_valid_i,
  output logic [NumIn-1:0] inp_ready_o,
  input  T                 inp_data_i [NumIn],
  output logic             oup_valid_o,
  input  logic             oup_ready_i,
  output T                 oup_data_o,
  output logic [IdxW-1:0]  oup_idx_o,
  input  logic             flush_req_i,
  output logic             flush_ack_o,
  output logic [1:0]       dropped_o,
  output logic             busy_o
);

  localparam logic [1:0] StIdle  = FlIdle;
  localparam logic [1:0] StFlush = FlFlush;
  localparam logic [1:0] StAck   = FlAck;

  typedef struct packed {
    logic [IdxW-1:0] idx;
    T                data;
  } arb_beat_t;

  logic [1:0]       state_q, state_d;
  logic [IdxW-1:0]  rr_q, grant;
  logic [1:0]       occ_q, dropped_q;
  logic [MaxIn-1:0] valid_ext;
  rr_pick_t         pick;
  logic             idle, flushing, grant_valid;
  logic             spill_valid_in, spill_ready_out, spill_valid_out, spill_ready_in;
  logic             in_hs, out_hs;
  arb_beat_t        beat_in, beat_out;

  assign idle     = (state_q == StIdle);
  assign flushing = (state_q == StFlush);

  always_comb begin
    valid_ext              = '0;
    valid_ext[NumIn-1:0]   = inp_valid_i;
  end

  assign pick        = rr_pick(valid_ext, 32'(rr_q), NumIn);
  assign grant       = IdxW'(pick.idx);
  assign grant_valid = pick.found & idle;

  always_comb begin
    inp_ready_o = '0;
    if (grant_valid && spill_ready_out) inp_ready_o[grant] = 1'b1;
  end

  // Valid-in is only possible in idle, so the spill stage never sees flush together with valid.
  assign spill_valid_in = grant_valid;
  assign spill_ready_in = oup_ready_i & ~flushing;
  assign beat_in.idx    = grant;
  assign beat_in.data   = inp_data_i[grant];

  spill_register_flushable #(
    .T      (arb_beat_t),
    .Bypass (1'b0)
  ) i_spill (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (spill_valid_in),
    .flush_i (flushing),
    .ready_o (spill_ready_out),
    .data_i  (beat_in),
    .valid_o (spill_valid_out),
    .ready_i (spill_ready_in),
    .data_o  (beat_out)
  );

  assign oup_valid_o = spill_valid_out & ~flushing;
  assign oup_data_o  = beat_out.data;
  assign oup_idx_o   = beat_out.idx;

  assign in_hs  = spill_valid_in & spill_ready_out;
  assign out_hs = oup_valid_o & oup_ready_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (flush_req_i) state_d = StFlush;
      StFlush: state_d = StAck;
      StAck:   if (!flush_req_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      rr_q      <= '0;
      occ_q     <= '0;
      dropped_q <= '0;
    end else begin
      state_q <= state_d;
      if (in_hs) rr_q <= (grant == IdxW'(NumIn - 1)) ? '0 : grant + IdxW'(1);
      if (flushing) begin
        dropped_q <= occ_q;
        occ_q     <= '0;
      end else begin
        occ_q <= occ_q + {1'b0, in_hs} - {1'b0, out_hs};
      end
    end
  end

  assign flush_ack_o = (state_q == StAck);
  assign dropped_o   = dropped_q;
  assign busy_o      = (occ_q != 2'd0) || !idle;

  a_no_flush_with_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(flushing && spill_valid_in));
  a_occ_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(in_hs && !out_hs && occ_q == 2'd2));
  a_occ_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(out_hs && !in_hs && occ_q == 2'd0));
  a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(inp_ready_o));

endmodule

// File: doc/stream_rr_arbiter_flushable.md
# stream_rr_arbiter_flushable

Round-robin arbiter that shares one flushable, fully registered output channel among `NumIn` valid/ready requesters. The output channel is a two-entry spill stage, so there is no combinational path from `oup_ready_i` to any `inp_ready_o`. A flush controller sequences discarding of buffered beats and guarantees that the spill stage never sees flush and valid in the same cycle. It sits between several producer streams and a single downstream consumer that must be drainable on abort (e.g. on a context switch).

## Interface
- `NumIn`, 4: number of requesters; must be ≥ 1.
- `T`, `logic [31:0]`: payload type.
- `IdxW`, `max(1, $clog2(NumIn))`: derived; width of the source index.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `inp_valid_i` in `[NumIn]`: requester valid.
- `inp_ready_o` out `[NumIn]`: requester ready; at most one bit high per cycle.
- `inp_data_i` in `[NumIn]` × `T`: requester payload.
- `oup_valid_o` out 1: output valid.
- `oup_ready_i` in 1: output ready.
- `oup_data_o` out `T`: output payload.
- `oup_idx_o` out `IdxW`: index of the requester that sourced `oup_data_o`.
- `flush_req_i` in 1: level request to discard all buffered beats.
- `flush_ack_o` out 1: flush complete; held until `flush_req_i` falls.
- `dropped_o` out 2: number of beats discarded; valid while `flush_ack_o` is high.
- `busy_o` out 1: high when a beat is buffered or a flush is in progress.

## Operation
- Flush FSM states: `FlIdle`, `FlFlush`, `FlAck`. Transitions:
  - `FlIdle` → `FlFlush` when `flush_req_i` is high.
  - `FlFlush` → `FlAck` unconditionally, after one cycle.
  - `FlAck` → `FlIdle` when `flush_req_i` is low.
- Arbitration is enabled only in `FlIdle`.
  - Grant `g` is the first index with `inp_valid_i` high, searching cyclically from pointer `rr_q`.
  - `inp_ready_o[g]` = spill-stage ready AND state == `FlIdle`. All other ready bits are 0.
- Input handshake on `g`:
  - `{g, inp_data_i[g]}` is pushed into the spill stage.
  - `rr_q <= (g + 1) mod NumIn`. Wrap is explicit, so `NumIn` need not be a power of two.
- `rr_q` is unchanged when no handshake occurs. The grant may move to a different requester while the spill stage is full; requesters must hold valid until their handshake.
- Occupancy counter `occ_q` (0..2): +1 on an input handshake, −1 on an output handshake, net 0 when both occur in the same cycle. Underflow or overflow is an assertion failure.
- In `FlFlush`:
  - Spill flush is asserted for exactly one cycle.
  - Spill valid-in is forced to 0 and all `inp_ready_o` are 0.
  - `oup_valid_o` is forced to 0, so no beat leaves during the flush cycle.
  - `dropped_q <= occ_q`, then `occ_q <= 0`.
- `flush_ack_o` = state == `FlAck`. `dropped_o` = `dropped_q`.
- `busy_o` = (`occ_q` ≠ 0) OR (state ≠ `FlIdle`).
- Reset values:
  - State `FlIdle`; `rr_q`, `occ_q`, `dropped_q` all 0.
  - `oup_valid_o`, `flush_ack_o`, `busy_o`, `dropped_o` all 0.
  - `inp_ready_o` = 0 while every `inp_valid_i` is 0.
  - `oup_data_o` and `oup_idx_o` = 0.
- Reset mid-operation: all buffered beats are lost silently and any flush in progress is abandoned without an ack.

## Timing
- Input-to-output latency is 1 cycle: a beat accepted at edge t is visible on `oup_*` after edge t.
- Throughput is 1 beat per cycle with `oup_ready_i` held high.
- With `oup_ready_i` low, exactly 2 beats are accepted, then all `inp_ready_o` are 0.
- `inp_ready_o` depends combinationally on `inp_valid_i` and registered state only, never on `oup_ready_i`.
- Flush sampled high in `FlIdle` at cycle t:
  - A handshake in cycle t is still allowed and is counted in `dropped_o`.
  - Cycle t+1 is `FlFlush`.
  - From cycle t+2, `flush_ack_o` is high.
  - Arbitration resumes the cycle after `flush_req_i` is seen low in `FlAck`.
- An output handshake in cycle t, the same cycle `flush_req_i` is first sampled, is counted before capture: it is not dropped.

## Structure
- Package `stream_arb_pkg`:
  - `flush_state_e` enum.
  - Packed struct `arb_beat_t` = `{idx, data}`, parameterised through the module.
  - Function `rr_pick(valid, ptr)`, which returns the grant index and a found flag.
- Sub-module: the existing `spill_register_flushable` common cell with `T = arb_beat_t` and `Bypass = 0`. This is the only instance.
- Flush-vs-valid exclusivity is enforced by the FSM gating and checked by an assertion in this block.

## Test plan
- Reset, then `NumIn = 4`, all valid, `oup_ready_i = 1` → `oup_idx_o` sequence 0,1,2,3,0; one beat per cycle after 1-cycle latency.
- Only requesters 1 and 3 valid, `rr_q = 2` → first grant 3, then 1, then 3; requester 0 never receives ready.
- `oup_ready_i = 0`, all valid → exactly 2 input handshakes, then all `inp_ready_o = 0`; `busy_o = 1`. Raise `oup_ready_i` → both beats emerge in order.
- Buffer 2 beats, pulse `flush_req_i` high for 3 cycles:
  - `FlFlush` cycle: `oup_valid_o = 0` and no input ready.
  - `flush_ack_o` high from t+2 until req low, with `dropped_o = 2`.
  - Afterwards `busy_o = 0` and `oup_valid_o = 0`.
- Flush with an empty buffer → `dropped_o = 0` and ack after 2 cycles. Flush while all inputs are valid → zero input handshakes during `FlFlush`/`FlAck`; the assertion never fires.
- Drive `rst_ni` low with 1 beat buffered and state `FlAck` → all outputs 0 immediately (asynchronously); after release the state is `FlIdle` and the next grant is index 0.
